qed_commit_checker: RTL and testbench

Commit-side consistency checker for SQED. It observes architectural register writebacks and queues each original-half result (registers r1–r15). It pops and compares against every duplicate-half result (r17–r31, r = original + 16). It raises a sticky error on the first inconsistency and a ready flag when all originals have been matched. It sits beside the core's writeback stage, consuming the result stream produced by the `qed` instruction-duplication front end.

---
 rtl/qed_chk_pkg.sv | 24 ++
 rtl/qed_wb_fifo.sv | 73 +++++++
 rtl/qed_commit_checker.sv | 126 ++++++++++++
 tb/tb_qed_commit_checker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/qed_chk_pkg.sv
// Shared types and constants for the SQED commit-side consistency checker.
package qed_chk_pkg;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_MISMATCH  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } qed_err_e;

  localparam logic [4:0] DUP_OFFSET = 5'd16;
  localparam int QED_DATA_W = 32;

  typedef struct packed {
    logic [3:0]            addr;
    logic [QED_DATA_W-1:0] data;
  } qed_entry_t;

  // Flat storage width of one pending-original entry.
  function automatic int entry_w(input int data_w);
    return data_w + 4;
  endfunction

endpackage

// File: rtl/qed_wb_fifo.sv
// Pending-original queue: occupancy-tracked FIFO with a combinational head view.
module qed_wb_fifo
  import qed_chk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 36,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Guard pointer movement against full/empty; pointers wrap modulo DEPTH.
  always_comb begin
    do_push_s = push && (level_r != LVL_MAX);
    do_pop_s  = pop && (level_r != {LW{1'b0}});
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (do_push_s && !do_pop_s) begin
        level_r <= level_r + LVL_ONE;
      end else if (do_pop_s && !do_push_s) begin
        level_r <= level_r - LVL_ONE;
      end else begin
        level_r <= level_r;
      end
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == LVL_MAX);
  assign empty = (level_r == {LW{1'b0}});

endmodule

// File: rtl/qed_commit_checker.sv
// Pairs original-half writebacks with their duplicates and flags the first
// inconsistency; all outputs come straight from registers.
module qed_commit_checker
  import qed_chk_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     wb_vld,
  input  logic [4:0]               wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     qed_ready,
  output logic                     qed_error,
  output logic [1:0]               err_code,
  output logic [CNT_W-1:0]         pair_cnt,
  output logic [$clog2(DEPTH):0]   q_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = entry_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [EW-1:0]     head_s;
  logic [3:0]        head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic [LW-1:0]     level_s;
  logic [LW-1:0]     level_nxt_s;
  logic              full_s;
  logic              empty_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              match_s;
  logic              err_set_s;
  qed_err_e          err_cause_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              ready_nxt_s;

  qed_err_e          err_code_r;
  logic              qed_error_r;
  logic              qed_ready_r;
  logic [CNT_W-1:0]  pair_cnt_r;

  qed_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({wb_addr[3:0], wb_data}),
    .head  (head_s),
    .level (level_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Classify by wb_addr[4]; r0/r16 never participate and an error freezes all.
  always_comb begin
    head_addr_s = head_s[EW-1:DATA_W];
    head_data_s = head_s[DATA_W-1:0];
    accept_s    = ena && wb_vld && !qed_error_r && (wb_addr[3:0] != 4'd0);
    match_s     = (({1'b0, head_addr_s} + DUP_OFFSET) == wb_addr) &&
                  (head_data_s == wb_data);
    push_s      = 1'b0;
    pop_s       = 1'b0;
    err_set_s   = 1'b0;
    err_cause_s = ERR_NONE;
    cnt_nxt_s   = pair_cnt_r;
    if (accept_s) begin
      if (!wb_addr[4]) begin
        if (full_s) begin
          err_set_s   = 1'b1;
          err_cause_s = ERR_OVERFLOW;
        end else begin
          push_s = 1'b1;
        end
      end else begin
        if (empty_s) begin
          err_set_s   = 1'b1;
          err_cause_s = ERR_UNDERFLOW;
        end else begin
          pop_s = 1'b1;
          if (match_s) begin
            cnt_nxt_s = (pair_cnt_r == {CNT_W{1'b1}}) ? pair_cnt_r : pair_cnt_r + CNT_ONE;
          end else begin
            err_set_s   = 1'b1;
            err_cause_s = ERR_MISMATCH;
          end
        end
      end
    end else begin
      push_s = 1'b0;
    end
    level_nxt_s = level_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    ready_nxt_s = (cnt_nxt_s != {CNT_W{1'b0}}) && (level_nxt_s == {LW{1'b0}}) &&
                  !(qed_error_r || err_set_s);
  end

  // Sticky error, saturating pair counter and registered ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_code_r  <= ERR_NONE;
      qed_error_r <= 1'b0;
      qed_ready_r <= 1'b0;
      pair_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (err_set_s) begin
        err_code_r  <= err_cause_s;
        qed_error_r <= 1'b1;
      end
      pair_cnt_r  <= cnt_nxt_s;
      qed_ready_r <= ready_nxt_s;
    end
  end

  assign qed_ready = qed_ready_r;
  assign qed_error = qed_error_r;
  assign err_code  = err_code_r;
  assign pair_cnt  = pair_cnt_r;
  assign q_level   = level_s;

endmodule

// File: tb/tb_qed_commit_checker.sv
// Directed self-checking bench for qed_commit_checker (DEPTH=16).
module tb_qed_commit_checker;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        wb_vld;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        qed_ready;
  logic        qed_error;
  logic [1:0]  err_code;
  logic [15:0] pair_cnt;
  logic [4:0]  q_level;

  int n_vec;
  int n_err;
  logic [35:0] mq[$];

  qed_commit_checker #(.DEPTH(16), .DATA_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .wb_vld    (wb_vld),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .qed_ready (qed_ready),
    .qed_error (qed_error),
    .err_code  (err_code),
    .pair_cnt  (pair_cnt),
    .q_level   (q_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One writeback driven for a single cycle; outputs are sampled at the following negedge.
  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_vld  = 1'b1;
    wb_addr = a;
    wb_data = d;
    @(negedge clk);
    wb_vld  = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic err,
                           input logic [1:0] code, input logic [15:0] cnt, input logic [4:0] lvl);
    check({tag, ".ready"}, 64'(qed_ready), 64'(rdy));
    check({tag, ".error"}, 64'(qed_error), 64'(err));
    check({tag, ".code"},  64'(err_code),  64'(code));
    check({tag, ".pairs"}, 64'(pair_cnt),  64'(cnt));
    check({tag, ".level"}, 64'(q_level),   64'(lvl));
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_all(tag, 1'b0, 1'b0, 2'd0, 16'd0, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
  endtask

  task automatic push_orig(input int i);
    logic [3:0]  a;
    logic [31:0] d;
    a = 4'((i % 15) + 1);
    d = 32'hA000_0000 + 32'(i);
    mq.push_back({a, d});
    wb({1'b0, a}, d);
  endtask

  task automatic pop_dup();
    logic [35:0] e;
    e = mq.pop_front();
    wb({1'b1, e[35:32]}, e[31:0]);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    ena     = 1'b1;
    wb_vld  = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
    @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 2'd0, 16'd0, 5'd0);
    rst = 1'b1;
    @(negedge clk);

    // Ignored writes: r0, r16 and anything with ena low.
    wb(5'd0,  32'hFFFF_FFFF);
    wb(5'd16, 32'hFFFF_FFFF);
    ena = 1'b0;
    wb(5'd4,  32'h0000_0044);
    wb(5'd20, 32'h0000_0044);
    ena = 1'b1;
    check_all("ignored", 1'b0, 1'b0, 2'd0, 16'd0, 5'd0);

    // Basic match.
    wb(5'd3, 32'h0000_00A5);
    check_all("match.push", 1'b0, 1'b0, 2'd0, 16'd0, 5'd1);
    wb(5'd19, 32'h0000_00A5);
    check_all("match.pop", 1'b1, 1'b0, 2'd0, 16'd1, 5'd0);

    // ena low does not flush the queue.
    wb(5'd7, 32'h0000_0077);
    check_all("hold.push", 1'b0, 1'b0, 2'd0, 16'd1, 5'd1);
    ena = 1'b0;
    @(negedge clk);
    check("hold.level", 64'(q_level), 64'd1);
    ena = 1'b1;
    wb(5'd23, 32'h0000_0077);
    check_all("hold.pop", 1'b1, 1'b0, 2'd0, 16'd2, 5'd0);

    // Mismatch, then later pairs are frozen out.
    wb(5'd5,  32'h1234_5678);
    wb(5'd21, 32'h1234_5679);
    check_all("mismatch", 1'b0, 1'b1, 2'd1, 16'd2, 5'd0);
    wb(5'd6,  32'h0000_0006);
    wb(5'd22, 32'h0000_0006);
    check_all("frozen", 1'b0, 1'b1, 2'd1, 16'd2, 5'd0);

    // Mismatch on register index alone.
    do_reset("rst1");
    wb(5'd9,  32'h0000_0099);
    wb(5'd26, 32'h0000_0099);
    check_all("addr_mis", 1'b0, 1'b1, 2'd1, 16'd0, 5'd0);

    // Underflow as the first write.
    do_reset("rst2");
    wb(5'd17, 32'h0000_0000);
    check_all("underflow", 1'b0, 1'b1, 2'd2, 16'd0, 5'd0);

    // Fill, partial drain, refill across the wrap, full drain, then overflow.
    do_reset("rst3");
    for (int i = 0; i < 16; i++) push_orig(i);
    check_all("fill16", 1'b0, 1'b0, 2'd0, 16'd0, 5'd16);
    for (int i = 0; i < 8; i++) pop_dup();
    check_all("drain8", 1'b0, 1'b0, 2'd0, 16'd8, 5'd8);
    for (int i = 16; i < 24; i++) push_orig(i);
    check_all("refill", 1'b0, 1'b0, 2'd0, 16'd8, 5'd16);
    for (int i = 0; i < 16; i++) pop_dup();
    check_all("drain16", 1'b1, 1'b0, 2'd0, 16'd24, 5'd0);
    for (int i = 24; i < 40; i++) push_orig(i);
    check_all("full_again", 1'b0, 1'b0, 2'd0, 16'd24, 5'd16);
    wb(5'd12, 32'hDEAD_BEEF);
    check_all("overflow", 1'b0, 1'b1, 2'd3, 16'd24, 5'd16);

    // Reset with entries queued, then a clean pair.
    do_reset("rst4");
    for (int i = 0; i < 5; i++) push_orig(i);
    check("mid.level", 64'(q_level), 64'd5);
    do_reset("mid_reset");
    wb(5'd2,  32'hCAFE_0002);
    check_all("post.push", 1'b0, 1'b0, 2'd0, 16'd0, 5'd1);
    wb(5'd18, 32'hCAFE_0002);
    check_all("post.pop", 1'b1, 1'b0, 2'd0, 16'd1, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
